// File: rtl/m68k_bus_target_if.sv
// ----------------------------------------------------------------------------
// m68k_bus_target_if
// Purpose : request side of a 68000 asynchronous bus cycle, as driven by the
//           bus master and decoded by m68k_bus_target.
// Signals : a      A[23:1] word address
//           as_n   address strobe, active low
//           uds_n  upper data strobe (D[15:8]), active low
//           lds_n  lower data strobe (D[7:0]), active low
//           rw     1 = read, 0 = write
// The data bus and DTACK_n are board-level tristate/open-drain nets and stay
// plain ports on the target so they can be resolved against pull-ups.
// ----------------------------------------------------------------------------
interface m68k_bus_target_if;
    logic [23:1] a;
    logic        as_n;
    logic        uds_n;
    logic        lds_n;
    logic        rw;

    modport master (output a, as_n, uds_n, lds_n, rw);
    modport slave  (input  a, as_n, uds_n, lds_n, rw);
endinterface

// File: rtl/m68k_bus_target.sv
// ----------------------------------------------------------------------------
// m68k_bus_target
// Purpose : target end of 68000 asynchronous bus cycles. Decodes AS/UDS/LDS/
//           RW/A, inserts WAIT_STATES clocks before DTACK, sources read data
//           and captures byte-lane writes into a 2^ADDR_BITS x 16 register
//           file. The top index is a read-only 16-bit access counter.
// Ports   : i_clk          bus clock, all state changes on rising edge
//           i_rst          async active-high reset
//           bus            request signals (A, AS_n, UDS_n, LDS_n, RW)
//           io_m68k_d      data bus, driven only during ACK of a read hit
//           o_m68k_dtack_n 0 during ACK, else Z (board pull-up)
//           i_host_addr    local read-port index
//           o_host_rdata   regfile[i_host_addr], combinational
//           o_wr_pulse     one-clock pulse per accepted write
//
// state  | meaning
// S_IDLE | waiting for AS_n low with a data strobe
// S_WAIT | hit decoded, counting down wait states
// S_ACK  | DTACK_n asserted until AS_n rises
// S_MISS | address not ours, wait for AS_n to rise
// ----------------------------------------------------------------------------
module m68k_bus_target #(
    parameter logic [23:1] BASE_ADDR   = 23'h740000,
    parameter int          ADDR_BITS   = 4,
    parameter int          WAIT_STATES = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    m68k_bus_target_if.slave     bus,
    inout  tri   [15:0]          io_m68k_d,
    output tri                   o_m68k_dtack_n,
    input  logic [ADDR_BITS-1:0] i_host_addr,
    output logic [15:0]          o_host_rdata,
    output logic                 o_wr_pulse
);

    localparam int                   DEPTH     = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] COUNT_IDX = '1;
    localparam bit                   NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0]           WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_MISS = 2'd3
    } state_t;

    state_t               r_state;
    logic [3:0]           r_wcnt;
    logic [ADDR_BITS-1:0] r_idx;
    logic                 r_rw;
    logic [15:0]          r_count;
    logic [15:0]          r_mem [DEPTH];
    logic                 r_wr_pulse;

    logic                 w_hit;
    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_ds;
    logic                 w_start;
    logic                 w_enter_ack;
    logic [ADDR_BITS-1:0] w_wr_idx;
    logic                 w_wr_rw;
    logic                 w_do_wr;
    logic [15:0]          w_rdata;
    logic                 w_d_oe;

    always_comb begin
        w_hit   = (bus.a[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]);
        w_idx   = bus.a[ADDR_BITS:1];
        w_ds    = !bus.uds_n || !bus.lds_n;
        // A write cycle's data strobes lag AS, so decode waits for a strobe.
        w_start = (r_state == S_IDLE) && !bus.as_n && w_ds;
        w_enter_ack = (w_start && w_hit && NO_WAIT) ||
                      ((r_state == S_WAIT) && !bus.as_n && (r_wcnt == 4'd0));
        // With no wait states the write lands on the decode edge itself, so
        // the live pins are used; otherwise the values latched at decode.
        w_wr_idx = (r_state == S_IDLE) ? w_idx : r_idx;
        w_wr_rw  = (r_state == S_IDLE) ? bus.rw : r_rw;
        w_do_wr  = w_enter_ack && !w_wr_rw;
        w_rdata  = (r_idx == COUNT_IDX) ? r_count : r_mem[r_idx];
        // Gated by the live AS_n so the bus is released in the same cycle
        // the master lets go, not one edge later.
        w_d_oe   = (r_state == S_ACK) && r_rw && !bus.as_n;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_wcnt  <= 4'd0;
            r_idx   <= '0;
            r_rw    <= 1'b1;
            r_count <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_idx <= w_idx;
                        r_rw  <= bus.rw;
                        if (!w_hit) begin
                            r_state <= S_MISS;
                        end else if (NO_WAIT) begin
                            r_state <= S_ACK;
                        end else begin
                            r_state <= S_WAIT;
                            r_wcnt  <= WCNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.as_n) begin
                        r_state <= S_IDLE;
                    end else if (r_wcnt == 4'd0) begin
                        r_state <= S_ACK;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                S_ACK: begin
                    if (bus.as_n) begin
                        r_state <= S_IDLE;
                        r_count <= r_count + 16'd1;
                    end
                end
                S_MISS: begin
                    if (bus.as_n) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The counter slot still acknowledges and pulses, but its storage word is
    // never written.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 16'd0;
            end
            r_wr_pulse <= 1'b0;
        end else begin
            r_wr_pulse <= w_do_wr;
            if (w_do_wr && (w_wr_idx != COUNT_IDX)) begin
                if (!bus.uds_n) begin
                    r_mem[w_wr_idx][15:8] <= io_m68k_d[15:8];
                end
                if (!bus.lds_n) begin
                    r_mem[w_wr_idx][7:0] <= io_m68k_d[7:0];
                end
            end
        end
    end

    assign io_m68k_d      = w_d_oe ? w_rdata : 16'hzzzz;
    assign o_m68k_dtack_n = (r_state == S_ACK) ? 1'b0 : 1'bz;
    assign o_host_rdata   = r_mem[i_host_addr];
    assign o_wr_pulse     = r_wr_pulse;

endmodule
